// File: rtl/pineball_motion_if.sv
// pineball_motion_if
//   Bundles the per-frame control inputs and the ball outputs of the
//   ball-motion engine.
//
//   Handshake: there is no valid/ready pair. frame_start is a one-clk
//   strobe from the VGA timing driver; launch, pause and paddle_x only
//   matter on the clk edge where frame_start=1. pineball_x/pineball_y/
//   state are valid one clk after that edge and hold until the next
//   strobe. bounce/miss are one-clk pulses in that same clk.
//
//   master : frame timing / game control side (drives the strobe and controls)
//   slave  : motion engine (drives position, state and event pulses)
interface pineball_motion_if;
  logic       frame_start;
  logic       launch;
  logic       pause;
  logic [9:0] paddle_x;
  logic [9:0] pineball_x;
  logic [9:0] pineball_y;
  logic [1:0] state;
  logic       bounce;
  logic       miss;

  modport master (
    output frame_start, launch, pause, paddle_x,
    input  pineball_x, pineball_y, state, bounce, miss
  );

  modport slave (
    input  frame_start, launch, pause, paddle_x,
    output pineball_x, pineball_y, state, bounce, miss
  );
endinterface

// File: rtl/pineball_motion.sv
// pineball_motion
//   Ball-motion engine feeding the frame renderer. The ball position is
//   updated only on frame_start so the picture never tears mid-frame.
//   Handles wall reflection, a bottom paddle, a miss/respawn hold, pause
//   and launch.
//
// Ports:
//   clk  : system/pixel clock
//   rst  : asynchronous, active-high reset
//   bus  : pineball_motion_if.slave
//          in  frame_start, launch, pause, paddle_x[9:0]
//          out pineball_x[9:0], pineball_y[9:0] (top-left of ball)
//              state[1:0] (00 IDLE, 01 RUN, 10 PAUSE, 11 MISS)
//              bounce, miss (one-clk pulses)
module pineball_motion #(
  parameter logic [9:0] H_DISP      = 10'd640,
  parameter logic [9:0] V_DISP      = 10'd480,
  parameter int         SIZE        = 5,
  parameter int         STEP        = 2,
  parameter int         FRAME_DIV   = 1,
  parameter logic [9:0] START_X     = 10'd320,
  parameter logic [9:0] START_Y     = 10'd240,
  parameter logic [9:0] PADDLE_Y    = 10'd440,
  parameter logic [9:0] PADDLE_W    = 10'd64,
  parameter int         MISS_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  pineball_motion_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_MISS  = 2'b11
  } state_t;

  // Ball covers x..x+SIZE inclusive, so the last legal left column is
  // H_DISP-1-SIZE (same for rows).
  localparam int XMAX    = int'(H_DISP) - 1 - SIZE;
  localparam int YMAX    = int'(V_DISP) - 1 - SIZE;
  localparam int PAD_TOP = int'(PADDLE_Y) - SIZE - 1;

  localparam logic signed [10:0] XMAX_S = 11'(XMAX);
  localparam logic signed [10:0] YMAX_S = 11'(YMAX);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] SIZE_S = 11'(SIZE);
  localparam logic signed [10:0] PADY_S = 11'(int'(PADDLE_Y));
  localparam logic signed [10:0] PADW_S = 11'(int'(PADDLE_W));

  localparam logic [9:0] XMAX_U    = 10'(XMAX);
  localparam logic [9:0] YMAX_U    = 10'(YMAX);
  localparam logic [9:0] PAD_TOP_U = 10'(PAD_TOP);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  localparam int MISS_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_FRAMES - 1);

  // Registered state
  state_t              state_q, state_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic                dir_x_q, dir_x_d;   // 1 = right (+)
  logic                dir_y_q, dir_y_d;   // 1 = down (+)
  logic [DIV_W-1:0]    div_q, div_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                bounce_q, bounce_d;
  logic                miss_q, miss_d;

  // Move evaluation
  logic                tick;
  logic signed [10:0]  x_s, y_s, nx, ny, pad_s;
  logic                hit_left, hit_right, hit_top, hit_paddle, hit_bottom;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (bus.frame_start) begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Move tick and collision evaluation
  // ---------------------------------------------------------------------
  always_comb begin
    tick  = 1'b0;
    div_d = div_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.launch) div_d = '0;
      end
      ST_RUN: begin
        // Pause wins over a pending move tick; the divider freezes too.
        if (!bus.pause) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            tick  = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    x_s   = {1'b0, x_q};
    y_s   = {1'b0, y_q};
    pad_s = {1'b0, bus.paddle_x};
    nx    = dir_x_q ? (x_s + STEP_S) : (x_s - STEP_S);
    ny    = dir_y_q ? (y_s + STEP_S) : (y_s - STEP_S);

    hit_left  = (nx < 11'sd0);
    hit_right = (nx > XMAX_S);
    hit_top   = (ny < 11'sd0);
    // Paddle only catches a descending ball whose bottom edge crosses the
    // paddle's top row during this step, with any column overlap.
    hit_paddle = dir_y_q
              && ((y_s + SIZE_S) < PADY_S)
              && ((ny + SIZE_S) >= PADY_S)
              && ((nx + SIZE_S) >= pad_s)
              && (nx <= (pad_s + PADW_S - 11'sd1));
    hit_bottom = !hit_paddle && (ny > YMAX_S);
  end

  // ---------------------------------------------------------------------
  // Datapath next values (committed only on frame_start)
  // ---------------------------------------------------------------------
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    miss_cnt_d = miss_cnt_q;
    bounce_d   = 1'b0;
    miss_d     = 1'b0;

    if (tick) begin
      // x and y reflections are independent; one bounce pulse covers both.
      bounce_d = hit_left | hit_right | hit_top | hit_paddle;

      if (hit_left) begin
        x_d     = '0;
        dir_x_d = 1'b1;
      end else if (hit_right) begin
        x_d     = XMAX_U;
        dir_x_d = 1'b0;
      end else begin
        x_d = nx[9:0];
      end

      if (hit_top) begin
        y_d     = '0;
        dir_y_d = 1'b1;
      end else if (hit_paddle) begin
        y_d     = PAD_TOP_U;
        dir_y_d = 1'b0;
      end else if (hit_bottom) begin
        y_d    = YMAX_U;
        miss_d = 1'b1;
      end else begin
        y_d = ny[9:0];
      end
    end

    if (state_q == ST_MISS) begin
      if (miss_cnt_q == MISS_LAST) begin
        miss_cnt_d = '0;
        x_d        = START_X;
        y_d        = START_Y;
        dir_x_d    = 1'b1;
        dir_y_d    = 1'b0;
      end else begin
        miss_cnt_d = miss_cnt_q + MISS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= START_X;
      y_q        <= START_Y;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b0;
      div_q      <= '0;
      miss_cnt_q <= '0;
      bounce_q   <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      // Event pulses last exactly the clk following the strobe.
      bounce_q <= 1'b0;
      miss_q   <= 1'b0;
      if (bus.frame_start) begin
        x_q        <= x_d;
        y_q        <= y_d;
        dir_x_q    <= dir_x_d;
        dir_y_q    <= dir_y_d;
        div_q      <= div_d;
        miss_cnt_q <= miss_cnt_d;
        bounce_q   <= bounce_d;
        miss_q     <= miss_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.launch) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.pause)                  state_d = ST_PAUSE;
        else if (tick && hit_bottom)    state_d = ST_MISS;
      end
      ST_PAUSE: if (!bus.pause) state_d = ST_RUN;
      ST_MISS:  if (miss_cnt_q == MISS_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus.pineball_x = x_q;
    bus.pineball_y = y_q;
    bus.state      = state_q;
    bus.bounce     = bounce_q;
    bus.miss       = miss_q;
  end

endmodule

// File: tb/tb_pineball_motion.sv
// tb_pineball_motion
//   Directed bench for pineball_motion: a vector table covering reset,
//   launch, pause and the first moves, followed by hand-written runs for
//   the top/right walls, paddle reflection, asynchronous reset and the
//   miss/respawn hold. Inputs are scrambled between strobes.
module tb_pineball_motion;

  logic clk = 1'b0;
  logic rst;

  pineball_motion_if bus_if();

  pineball_motion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {state[1:0], miss, x[9:0], y[9:0]}
  logic [22:0] exp_q[$];

  typedef struct {
    logic       l;
    logic       p;
    logic [9:0] px;
    logic [9:0] ex;
    logic [9:0] ey;
    logic [1:0] es;
    logic       eb;
    logic       em;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic noise();
    bus_if.launch   = 1'($urandom_range(0, 1));
    bus_if.pause    = 1'($urandom_range(0, 1));
    bus_if.paddle_x = 10'($urandom_range(0, 1023));
  endtask

  // One frame_start strobe; returns 1 time unit after the active edge.
  task automatic frame(input logic l, input logic p, input logic [9:0] px);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus_if.launch      = l;
    bus_if.pause       = p;
    bus_if.paddle_x    = px;
    bus_if.frame_start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.frame_start = 1'b0;
    noise();
  endtask

  task automatic frames(input int n, input logic l, input logic [9:0] px);
    for (int i = 0; i < n; i++) frame(l, 1'b0, px);
  endtask

  task automatic check_pos(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                           input logic [1:0] es, input logic eb);
    check({tag, " x"}, bus_if.pineball_x, ex);
    check({tag, " y"}, bus_if.pineball_y, ey);
    check({tag, " state"}, bus_if.state, es);
    check({tag, " bounce"}, bus_if.bounce, eb);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 10'd100, 10'd320, 10'd240, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 10'd100, 10'd320, 10'd240, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 10'd100, 10'd320, 10'd240, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 10'd100, 10'd320, 10'd240, 2'b01, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 10'd100, 10'd322, 10'd238, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 10'd100, 10'd324, 10'd236, 2'b01, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 10'd100, 10'd324, 10'd236, 2'b10, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 10'd100, 10'd324, 10'd236, 2'b10, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 10'd100, 10'd324, 10'd236, 2'b10, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 10'd100, 10'd324, 10'd236, 2'b10, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 10'd100, 10'd324, 10'd236, 2'b10, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 10'd100, 10'd324, 10'd236, 2'b01, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 10'd100, 10'd326, 10'd234, 2'b01, 1'b0, 1'b0};

    // Clock/reset
    rst                = 1'b1;
    bus_if.frame_start = 1'b0;
    bus_if.launch      = 1'b0;
    bus_if.pause       = 1'b0;
    bus_if.paddle_x    = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    check_pos("reset", 10'd320, 10'd240, 2'b00, 1'b0);
    check("reset miss", bus_if.miss, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table: idle, launch, first moves, pause/resume
    for (int i = 0; i < 13; i++) begin
      frame(vecs[i].l, vecs[i].p, vecs[i].px);
      check($sformatf("vec%0d x", i), bus_if.pineball_x, vecs[i].ex);
      check($sformatf("vec%0d y", i), bus_if.pineball_y, vecs[i].ey);
      check($sformatf("vec%0d state", i), bus_if.state, vecs[i].es);
      check($sformatf("vec%0d bounce", i), bus_if.bounce, vecs[i].eb);
      check($sformatf("vec%0d miss", i), bus_if.miss, vecs[i].em);
      repeat (2) begin
        @(posedge clk);
        noise();
      end
      #1;
      check($sformatf("vec%0d hold x", i), bus_if.pineball_x, vecs[i].ex);
      check($sformatf("vec%0d hold state", i), bus_if.state, vecs[i].es);
    end

    // Top wall: 3 moves done, y reaches 0 at move 120
    frames(116, 1'b0, 10'd250);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m120", 10'd560, 10'd0, 2'b01, 1'b0);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m121 top", 10'd562, 10'd0, 2'b01, 1'b1);
    @(posedge clk);
    #1;
    check("m121 bounce drop", bus_if.bounce, 1'b0);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m122", 10'd564, 10'd2, 2'b01, 1'b0);

    // Right wall at move 158
    frames(34, 1'b0, 10'd250);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m157", 10'd634, 10'd72, 2'b01, 1'b0);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m158 right", 10'd634, 10'd74, 2'b01, 1'b1);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m159", 10'd632, 10'd76, 2'b01, 1'b0);

    // Paddle at columns 250..313 catches the descent
    frames(178, 1'b0, 10'd250);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m338", 10'd274, 10'd434, 2'b01, 1'b0);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m339 paddle", 10'd272, 10'd434, 2'b01, 1'b1);
    frame(1'b0, 1'b0, 10'd250);
    check_pos("m340", 10'd270, 10'd432, 2'b01, 1'b0);

    // Asynchronous reset between strobes, away from any clk edge
    #1;
    rst = 1'b1;
    #1;
    check_pos("async rst", 10'd320, 10'd240, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Relaunch with paddle parked at 0; launch held high is ignored in RUN
    frame(1'b1, 1'b0, 10'd0);
    check_pos("relaunch", 10'd320, 10'd240, 2'b01, 1'b0);
    frames(357, 1'b1, 10'd0);
    frame(1'b1, 1'b0, 10'd0);
    check_pos("r358", 10'd234, 10'd474, 2'b01, 1'b0);
    frame(1'b1, 1'b0, 10'd0);
    check_pos("r359 miss", 10'd232, 10'd474, 2'b11, 1'b0);
    check("r359 miss pulse", bus_if.miss, 1'b1);
    @(posedge clk);
    #1;
    check("miss pulse drop", bus_if.miss, 1'b0);

    // Miss hold: 59 frames frozen, 60th respawns
    for (int i = 1; i <= 59; i++) exp_q.push_back({2'b11, 1'b0, 10'd232, 10'd474});
    exp_q.push_back({2'b00, 1'b0, 10'd320, 10'd240});
    for (int i = 1; i <= 60; i++) begin
      logic [22:0] e;
      frame(1'b1, 1'b1, 10'd0);
      e = exp_q.pop_front();
      check($sformatf("missf%0d", i),
            {bus_if.state, bus_if.miss, bus_if.pineball_x, bus_if.pineball_y}, e);
    end

    // Respawned ball stays idle until launched, then heads up-right again
    frame(1'b0, 1'b0, 10'd0);
    check_pos("respawn idle", 10'd320, 10'd240, 2'b00, 1'b0);
    frame(1'b1, 1'b0, 10'd0);
    check_pos("respawn launch", 10'd320, 10'd240, 2'b01, 1'b0);
    frame(1'b0, 1'b0, 10'd0);
    check_pos("respawn move", 10'd322, 10'd238, 2'b01, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
